// File: rtl/linebuffer_pair_pkg.sv
// Shared line-buffer constants and state encoding, used by the sprite renderer,
// the line buffer and the palette output stage.
package linebuffer_pair_pkg;

  localparam int unsigned LB_DATA_W  = 12;
  localparam int unsigned LB_DEPTH   = 384;
  localparam int unsigned LB_ADDR_W  = 9;
  localparam int unsigned LB_CLR_VAL = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } lb_state_e;

endpackage

// File: rtl/linebuffer_pair_lb_bank.sv
// One DEPTH x DATA_W pixel bank: a write port plus a read-first read/clear port.
module lb_bank
  import linebuffer_pair_pkg::*;
#(
  parameter int unsigned          DATA_W  = LB_DATA_W,
  parameter int unsigned          DEPTH   = LB_DEPTH,
  parameter int unsigned          ADDR_W  = LB_ADDR_W,
  parameter logic [DATA_W-1:0]    CLR_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rclr,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Caller masks out-of-range addresses; the read value is registered upstream.
  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge i_clk) begin
    if (i_rclr) r_mem[i_raddr] <= CLR_VAL;
    if (i_we)   r_mem[i_waddr] <= i_wdata;
  end

endmodule

// File: rtl/linebuffer_pair.sv
// Double-buffered sprite line buffer: one bank renders while the other streams
// out with clear-after-read; a reset-triggered sweep clears both banks.
module linebuffer_pair
  import linebuffer_pair_pkg::*;
#(
  parameter int unsigned DATA_W    = LB_DATA_W,
  parameter int unsigned DEPTH     = LB_DEPTH,
  parameter int unsigned ADDR_W    = LB_ADDR_W,
  parameter int unsigned TRANSP_EN = 1,
  parameter int unsigned CLR_VAL   = LB_CLR_VAL
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              FLIP,
  input  logic              WE,
  input  logic              LDX,
  input  logic [ADDR_W-1:0] XPOS,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LDR,
  input  logic [ADDR_W-1:0] RPOS,
  output logic [DATA_W-1:0] DOUT,
  output logic              BUSY,
  output logic              BANK
);

  localparam logic [DATA_W-1:0] CLR_W      = DATA_W'(CLR_VAL);
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_SWEEP = ADDR_W'(DEPTH - 1);

  lb_state_e         r_state;
  logic [ADDR_W-1:0] r_sweep;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_rcnt;
  logic              r_bank;
  logic              r_busy;
  logic [DATA_W-1:0] r_dout;

  logic              w_run;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_wr_en;
  logic              w_rd_in;
  logic [ADDR_W-1:0] w_bwaddr;
  logic [DATA_W-1:0] w_bwdata;
  logic [1:0]        w_bwe;
  logic [1:0]        w_brclr;
  logic [DATA_W-1:0] w_rdata [2];

  assign w_run   = (r_state == ST_RUN);
  assign w_waddr = LDX ? XPOS : r_wcnt;
  assign w_raddr = LDR ? RPOS : r_rcnt;
  assign w_rd_in = ({1'b0, w_raddr} < DEPTH_C);
  assign w_wr_en = w_run && WE && ({1'b0, w_waddr} < DEPTH_C)
                   && !((TRANSP_EN != 0) && (DIN[3:0] == 4'h0));

  // During the sweep the write port of both banks carries the clear value.
  assign w_bwaddr   = w_run ? w_waddr : r_sweep;
  assign w_bwdata   = w_run ? DIN : CLR_W;
  assign w_bwe[0]   = w_run ? (w_wr_en && !r_bank) : 1'b1;
  assign w_bwe[1]   = w_run ? (w_wr_en &&  r_bank) : 1'b1;
  assign w_brclr[0] = w_run && w_rd_in &&  r_bank;
  assign w_brclr[1] = w_run && w_rd_in && !r_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lb_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CLR_VAL(CLR_W)
    ) u_bank (
      .i_clk  (CK),
      .i_we   (w_bwe[b]),
      .i_waddr(w_bwaddr),
      .i_wdata(w_bwdata),
      .i_rclr (w_brclr[b]),
      .i_raddr(w_raddr),
      .o_rdata(w_rdata[b])
    );
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= ST_CLEAR;
      r_sweep <= '0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_bank  <= 1'b0;
      r_busy  <= 1'b1;
      r_dout  <= CLR_W;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_dout  <= CLR_W;
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == LAST_SWEEP) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_wcnt <= w_waddr + 1'b1;
          r_rcnt <= w_raddr + 1'b1;
          r_dout <= w_rd_in ? (r_bank ? w_rdata[0] : w_rdata[1]) : CLR_W;
          if (FLIP) r_bank <= ~r_bank;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign DOUT = r_dout;
  assign BUSY = r_busy;
  assign BANK = r_bank;

endmodule

// File: tb/tb_linebuffer_pair.sv
// Directed bench for linebuffer_pair with a read scoreboard; a second instance
// with transparency disabled shares the stimulus.
module tb_linebuffer_pair;

  localparam int unsigned DW  = 12;
  localparam int unsigned DEP = 384;
  localparam int unsigned AW  = 9;

  logic          CK = 1'b0;
  logic          RST, FLIP, WE, LDX, LDR;
  logic [AW-1:0] XPOS, RPOS;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT, DOUT2;
  logic          BUSY, BUSY2, BANK, BANK2;

  always #5 CK = ~CK;

  linebuffer_pair #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .TRANSP_EN(1), .CLR_VAL(0)) dut (
    .CK(CK), .RST(RST), .FLIP(FLIP), .WE(WE), .LDX(LDX), .XPOS(XPOS), .DIN(DIN),
    .LDR(LDR), .RPOS(RPOS), .DOUT(DOUT), .BUSY(BUSY), .BANK(BANK)
  );

  linebuffer_pair #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .TRANSP_EN(0), .CLR_VAL(0)) dut_nt (
    .CK(CK), .RST(RST), .FLIP(FLIP), .WE(WE), .LDX(LDX), .XPOS(XPOS), .DIN(DIN),
    .LDR(LDR), .RPOS(RPOS), .DOUT(DOUT2), .BUSY(BUSY2), .BANK(BANK2)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    bit            both;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 1'b0; FLIP = 1'b0; WE = 1'b0; LDX = 1'b0; LDR = 1'b0;
    XPOS = '0; RPOS = '0; DIN = '0;
  endtask

  // Every read pushed before a tick is due on DOUT right after that tick.
  task automatic tick();
    exp_t e;
    @(posedge CK);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(DOUT), 32'(e.v1));
      if (e.both) chk({e.tag, "_nt"}, 32'(DOUT2), 32'(e.v2));
    end
  endtask

  task automatic expect_rd(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag; e.v1 = v; e.v2 = v; e.both = 1'b0;
    sb.push_back(e);
  endtask

  task automatic flip_cycle();
    idle(); FLIP = 1'b1; tick(); idle();
  endtask

  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(DEP));
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned i, input int unsigned s);
    logic [7:0] hi;
    logic [3:0] lo;
    hi = 8'(i + s);
    lo = 4'(i % 15 + 1);
    return {hi, lo};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    idle();
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_busy_nt", 32'(BUSY2), 32'd1);
    chk("rst_bank", 32'(BANK), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    count_sweep("sweep_len");

    // Sustained: fill bank 0, then stream it out while filling bank 1.
    for (int i = 0; i < DEP; i++) begin
      WE = 1'b1; LDX = (i == 0); XPOS = '0; DIN = pat(i, 0); tick();
    end
    flip_cycle();
    chk("flip_bank", 32'(BANK), 32'd1);
    for (int i = 0; i < DEP; i++) begin
      WE = 1'b1; LDX = (i == 0); XPOS = '0; DIN = pat(i, 100);
      LDR = (i == 0); RPOS = '0;
      expect_rd("stream", pat(i, 0));
      tick();
    end
    flip_cycle();
    for (int i = 0; i < DEP; i++) begin
      WE = 1'b1; LDX = (i == 0); XPOS = '0; DIN = pat(i, 50); tick();
    end
    idle();

    // Reset in the middle of a sweep restarts it; both banks end up cleared.
    RST = 1'b1; tick(); RST = 1'b0;
    for (int k = 0; k < 200; k++) tick();
    chk("midsweep_busy", 32'(BUSY), 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rerst_bank", 32'(BANK), 32'd0);
    count_sweep("resweep_len");
    for (int i = 0; i < DEP; i++) begin
      LDR = (i == 0); RPOS = '0; expect_rd("clr_b1", '0); tick();
    end
    flip_cycle();
    for (int i = 0; i < DEP; i++) begin
      LDR = (i == 0); RPOS = '0; expect_rd("clr_b0", '0); tick();
    end
    idle();

    // Render and read back at X=10 (render bank 1), then clear-after-read.
    WE = 1'b1; LDX = 1'b1; XPOS = 9'd10; DIN = 12'h123; tick();
    LDX = 1'b0; DIN = 12'h456; tick();
    DIN = 12'h789; tick();
    flip_cycle();
    LDR = 1'b1; RPOS = 9'd10; expect_rd("rr0", 12'h123); tick();
    LDR = 1'b0; expect_rd("rr1", 12'h456); tick();
    expect_rd("rr2", 12'h789); tick();
    flip_cycle();
    flip_cycle();
    LDR = 1'b1; RPOS = 9'd10; expect_rd("reread0", '0); tick();
    LDR = 1'b0; expect_rd("reread1", '0); tick();
    expect_rd("reread2", '0); tick();
    chk("bank_after_rr", 32'(BANK), 32'd0);

    // WE + LDX + FLIP together: pixel lands at XPOS in the pre-flip bank.
    idle(); WE = 1'b1; LDX = 1'b1; XPOS = 9'd20; DIN = 12'hABC; FLIP = 1'b1; tick();
    idle();
    LDR = 1'b1; RPOS = 9'd20; expect_rd("we_flip", 12'hABC); tick();
    idle();

    // Transparency: 0x120 over 0x3A1 at X=5 (render bank 1).
    WE = 1'b1; LDX = 1'b1; XPOS = 9'd5; DIN = 12'h3A1; tick();
    DIN = 12'h120; tick();
    flip_cycle();
    LDR = 1'b1; RPOS = 9'd5;
    e.tag = "transp"; e.v1 = 12'h3A1; e.v2 = 12'h120; e.both = 1'b1;
    sb.push_back(e);
    tick();
    idle();

    // Bounds and wrap (render bank 0).
    WE = 1'b1; LDX = 1'b1; XPOS = 9'd382; DIN = 12'h111; tick();
    LDX = 1'b0; DIN = 12'h222; tick();
    DIN = 12'h333; tick();
    DIN = 12'h444; tick();
    LDX = 1'b1; XPOS = 9'd511; DIN = 12'h555; tick();
    LDX = 1'b0; DIN = 12'h666; tick();
    flip_cycle();
    LDR = 1'b1; RPOS = 9'd382; expect_rd("b382", 12'h111); tick();
    LDR = 1'b0; expect_rd("b383", 12'h222); tick();
    expect_rd("b384", '0); tick();
    expect_rd("b385", '0); tick();
    LDR = 1'b1; RPOS = 9'd511; expect_rd("r511", '0); tick();
    LDR = 1'b0; expect_rd("rwrap0", 12'h666); tick();
    LDR = 1'b1; RPOS = 9'd400; expect_rd("r400", '0); tick();
    idle();
    tick();
    chk("final_bank", 32'(BANK), 32'd1);
    chk("final_bank_nt", 32'(BANK2), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/linebuffer_pair.md
# linebuffer_pair

Double-buffered sprite line buffer: two banks of DEPTH pixels alternate roles. One bank is in render mode and takes pixel writes from the sprite engine. The other is in output mode and streams pixels to the video output stage, clearing each location after it is read. The block sits between the sprite renderer and the palette lookup. It supersedes the single-bank, fixed-size line buffer and adds bank swapping, transparency skipping, clear-after-read and a reset clear sweep.

## Interface
- DATA_W, 12: pixel width (palette index).
- DEPTH, 384: pixels per bank.
- ADDR_W, 9: counter width; must satisfy 2^ADDR_W >= DEPTH.
- TRANSP_EN, 1: when 1, a pixel with DIN[3:0]==0 is not written.
- CLR_VAL, 0: value written on clear, and value returned for reads with address >= DEPTH.

Ports:
- CK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- FLIP  in  1  swap bank roles at end of line; single-cycle pulse.
- WE  in  1  write DIN to the render bank at the write counter.
- LDX  in  1  load write counter from XPOS.
- XPOS  in  ADDR_W  write start position.
- DIN  in  DATA_W  render pixel.
- LDR  in  1  load read counter from RPOS.
- RPOS  in  ADDR_W  read start position.
- DOUT  out  DATA_W  output pixel, registered.
- BUSY  out  1  clear sweep in progress.
- BANK  out  1  index of the current render bank.

## Operation
State machine: CLEAR -> RUN.

RST (in any state, including mid-sweep):
- Enters CLEAR and restarts the sweep from address 0.
- BANK=0, write counter=0, read counter=0, DOUT=CLR_VAL, BUSY=1.

CLEAR:
- Writes CLR_VAL to address k of both banks on sweep cycle k, for k=0..DEPTH-1.
- Moves to RUN after DEPTH cycles, so BUSY=1 for exactly DEPTH cycles.
- WE, LDX, LDR and FLIP are ignored. DOUT holds CLR_VAL.

RUN, write side (render bank = BANK):
- LDX=1: write counter <= XPOS. If WE=1 in the same cycle, the write targets XPOS, not the old count.
- LDX=0: write counter <= write counter + 1, every cycle, whether or not WE=1. Wraps modulo 2^ADDR_W.
- A write occurs when WE=1, the effective address is < DEPTH, and the pixel is not transparent (TRANSP_EN=1 and DIN[3:0]==0). Otherwise the write is dropped, but the counter still advances.

RUN, read side (output bank = !BANK):
- Effective read address = RPOS if LDR=1, else the read counter.
- Next cycle: DOUT = mem[address], or CLR_VAL if address >= DEPTH.
- In the same cycle, CLR_VAL is written to that location (read-first).
- Read counter <= address + 1, wrapping modulo 2^ADDR_W.

FLIP in RUN:
- BANK toggles at the edge.
- Any write or read in the FLIP cycle uses the pre-flip bank assignment.
- Counters are not reset by FLIP.

## Timing
- Write: data is visible in the output bank after a FLIP, read 1 cycle after the address is presented.
- Read latency: 1 cycle from address (LDR/RPOS or counter) to DOUT.
- Clear-after-read: after reading address a once, a second read of a (after two FLIPs, with no render write to a) returns CLR_VAL.
- Throughput: one write and one read per cycle, sustained, on different banks.
- Reset recovery: first valid write or read occurs DEPTH cycles after RST deasserts (on the first cycle with BUSY=0).
- BANK, BUSY and DOUT are registered outputs with no combinational path from inputs.

## Structure
- A shared package holds the default DATA_W/DEPTH/ADDR_W and the CLR_VAL constant, for use by the sprite renderer and the output stage.
- Sub-module lb_bank: one DEPTH x DATA_W bank with one write port and one read-first read/clear port. It is instantiated twice. Bank-select muxing, counters and the CLEAR/RUN FSM live in the top level.

## Test plan
- Reset sweep: assert RST for 1 cycle -> BUSY=1 for exactly 384 cycles. Then read addresses 0..383 of both banks -> all 0.
- Render and read: LDX with XPOS=10, write 0x123, 0x456, 0x789 on consecutive cycles, then FLIP, then LDR with RPOS=10 -> DOUT=0x123, 0x456, 0x789 on cycles +1..+3. Re-reading after two FLIPs -> 0.
- Transparency: write 0x120 at X=5 over an existing 0x3A1 -> 0x3A1 survives. With TRANSP_EN=0 -> reads 0x120.
- Bounds and wrap: XPOS=382, write 4 pixels -> addresses 382 and 383 are written, 384 and 385 are dropped. Counter at 511 +1 -> 0. RPOS=400 -> DOUT=0.
- Simultaneous events: WE with FLIP in the same cycle -> the pixel lands in the old render bank. LDX with WE -> the pixel lands at XPOS. RST mid-sweep at k=200 -> sweep restarts and BUSY lasts 384 more cycles.
- Sustained throughput: 384 writes and 384 reads concurrently, then FLIP -> all written values are read back in order with no stalls.
